// File: rtl/i2c_bit_engine.sv
// Bit-level I2C line sequencer: runs START/STOP/WRITE/READ primitives over six
// phase ticks per SCL period, with clock stretching, arbitration loss and stretch timeout.
module i2c_bit_engine #(
    parameter int unsigned STRETCH_MAX = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_6x,
    input  logic [1:0] cmd,
    input  logic       din,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       done,
    output logic       dout,
    output logic       arb_lost,
    output logic       timeout,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);

    localparam int unsigned PH_W  = 3;
    localparam int unsigned CNT_W = $clog2(STRETCH_MAX + 1);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t           state_q;
    logic [PH_W-1:0]  phase_q;
    logic [CNT_W-1:0] stretch_q;
    logic [1:0]       cmd_q;
    logic             din_q;
    logic             cmd_ready_q, done_q, dout_q, arb_lost_q, timeout_q;
    logic             scl_oe_q, sda_oe_q;
    logic             scl_meta_q, scl_s_q, sda_meta_q, sda_s_q;
    logic             scl_oe_d, sda_oe_d;
    logic             arb_hit_c;

    // Pad synchronisers; reset to the idle (released, high) bus level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_meta_q <= 1'b1;
            scl_s_q    <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_s_q    <= 1'b1;
        end else begin
            scl_meta_q <= scl_in;
            scl_s_q    <= scl_meta_q;
            sda_meta_q <= sda_in;
            sda_s_q    <= sda_meta_q;
        end
    end

    // Line drive for the current phase; registered one clk later.
    always_comb begin
        scl_oe_d = (phase_q <= PH_W'(1)) ||
                   ((phase_q == PH_W'(5)) && (cmd_q != CMD_STOP));
        sda_oe_d = 1'b0;
        case (cmd_q)
            CMD_START: sda_oe_d = (phase_q >= PH_W'(4));
            CMD_STOP:  sda_oe_d = (phase_q <= PH_W'(3));
            CMD_WRITE: sda_oe_d = ~din_q;
            CMD_READ:  sda_oe_d = 1'b0;
            default:   sda_oe_d = 1'b0;
        endcase
    end

    assign arb_hit_c = (cmd_q == CMD_WRITE) && din_q &&
                       ((phase_q == PH_W'(3)) || (phase_q == PH_W'(4))) &&
                       scl_s_q && !sda_s_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            stretch_q   <= '0;
            cmd_q       <= CMD_START;
            din_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            dout_q      <= 1'b0;
            arb_lost_q  <= 1'b0;
            timeout_q   <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            arb_lost_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_q       <= cmd;
                        din_q       <= din;
                        phase_q     <= '0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    scl_oe_q <= scl_oe_d;
                    sda_oe_q <= sda_oe_d;
                    if (tick_6x) begin
                        if (arb_hit_c) begin
                            arb_lost_q  <= 1'b1;
                            scl_oe_q    <= 1'b0;
                            sda_oe_q    <= 1'b0;
                            phase_q     <= '0;
                            cmd_ready_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else if ((phase_q == PH_W'(3)) && !scl_s_q) begin
                            // Slave is stretching SCL: hold the phase and count.
                            if (stretch_q == CNT_W'(STRETCH_MAX - 1)) begin
                                timeout_q   <= 1'b1;
                                scl_oe_q    <= 1'b0;
                                sda_oe_q    <= 1'b0;
                                phase_q     <= '0;
                                cmd_ready_q <= 1'b1;
                                state_q     <= ST_IDLE;
                            end else begin
                                stretch_q <= stretch_q + CNT_W'(1);
                            end
                        end else if (phase_q == PH_W'(5)) begin
                            done_q      <= 1'b1;
                            phase_q     <= '0;
                            cmd_ready_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            if ((phase_q == PH_W'(3)) && (cmd_q == CMD_READ)) begin
                                dout_q <= sda_s_q;
                            end
                            if (phase_q == PH_W'(2)) begin
                                stretch_q <= '0;
                            end
                            phase_q <= phase_q + PH_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign dout      = dout_q;
    assign arb_lost  = arb_lost_q;
    assign timeout   = timeout_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;

endmodule

// File: doc/i2c_bit_engine.md
Name: i2c_bit_engine

Overview:
- Bit-level I2C line sequencer; sits directly downstream of clock_generator inside I2C_CORE.
- Consumes the 6x-SCL-rate phase tick and executes one of four bus primitives per command: START, STOP, WRITE bit, READ bit.
- Drives SCL/SDA through open-drain enables and supports clock stretching.
- Reports arbitration loss and stretch timeout to the byte-level controller above it.

Parameters:
- STRETCH_MAX, 1024, number of ticks SCL may be held low by a slave in phase P3 before a timeout abort.

Ports:
- clk  input  1  system clock, 50 MHz
- reset  input  1  asynchronous, active-low reset
- tick_6x  input  1  one-clk pulse from clock_generator; 6 ticks per SCL period
- cmd  input  2  00=START, 01=STOP, 10=WRITE, 11=READ
- din  input  1  bit to transmit (WRITE only)
- cmd_valid  input  1  command request
- cmd_ready  output  1  engine can accept a command
- done  output  1  one-clk pulse when a command completes normally
- dout  output  1  last bit sampled by READ
- arb_lost  output  1  one-clk pulse, arbitration lost
- timeout  output  1  one-clk pulse, stretch timeout
- scl_in  input  1  SCL pad level
- sda_in  input  1  SDA pad level
- scl_oe  output  1  1 = pull SCL low, 0 = release
- sda_oe  output  1  1 = pull SDA low, 0 = release

Behaviour:
- Reset (async, reset=0): state IDLE; scl_oe=0, sda_oe=0, cmd_ready=1, done=0, dout=0, arb_lost=0, timeout=0; phase=0; stretch counter=0. Reset mid-command releases both lines immediately.
- scl_in and sda_in pass through 2-flop synchronisers (scl_s, sda_s). All line checks use the synchronised values.
- Handshake:
  - Accept when cmd_valid & cmd_ready. cmd and din are latched; state becomes ACTIVE with phase=0; cmd_ready=0 from the next clk.
  - cmd_valid while cmd_ready=0 is ignored.
- Phase advance: in ACTIVE, each tick_6x advances phase 0→5. A tick in phase 5 ends the command: done=1 for one clk, cmd_ready=1 the same clk, state returns to IDLE.
- Line values per phase (registered; applied the clk after entering the phase):
  - SCL, all commands: P0–P1 low, P2–P4 released. P5 low, except STOP, which releases SCL in P5.
  - SDA, START: released P0–P3, low P4–P5.
  - SDA, STOP: low P0–P3, released P4–P5.
  - SDA, WRITE: sda_oe = ~din in all phases.
  - SDA, READ: released in all phases.
- IDLE: lines hold the values from the last phase of the previous command. Lines are released after STOP or abort; SCL stays low after START, WRITE or READ.
- Clock stretching: a tick in P3 advances only if scl_s=1.
  - Each tick in P3 with scl_s=0 increments the stretch counter.
  - When the counter reaches STRETCH_MAX: timeout=1 for one clk, both lines released, IDLE, cmd_ready=1, no done.
  - The counter clears on entering P3.
- READ: on the tick that advances P3→P4, dout ← sda_s. dout holds until the next READ sample.
- Arbitration: during WRITE with din=1, any tick in P3 or P4 with scl_s=1 and sda_s=0 causes an abort:
  - arb_lost=1 for one clk;
  - both lines released immediately;
  - IDLE, cmd_ready=1, no done.
- Simultaneous events:
  - Abort and phase-5 completion cannot coincide.
  - A new command can be accepted in the clk after done; it is never accepted in the same clk as done.
- Minimum command length: exactly 6 ticks without stretching.

Test Plan:
- Reset then idle: reset low mid-WRITE with din=0 → scl_oe=0 and sda_oe=0 immediately; after release, cmd_ready=1 and all pulses 0.
- START, WRITE 1, WRITE 0, STOP, no stretch, pads follow the oe outputs:
  - each command gives done after exactly 6 ticks;
  - SDA falls while SCL is high (START P4) and rises while SCL is high (STOP P4);
  - final state scl_oe=0, sda_oe=0.
- READ with a bench model driving SDA=0 during the SCL-high window → dout=0. READ with SDA released → dout=1. done after 6 ticks each.
- Stretching: slave holds SCL low for 20 ticks after P2 → phase stays at 3 and no timeout; command completes 20 ticks late with done=1.
- Timeout with STRETCH_MAX=8: slave holds SCL low permanently → timeout pulse after 8 ticks in P3, lines released, no done, cmd_ready=1.
- Arbitration: WRITE din=1 while another master forces SDA low with SCL high → arb_lost pulse, scl_oe=0, sda_oe=0, no done. Back-to-back cmd_valid during busy is ignored (only the first command executes).
